vco_dac_sweep_ctrl: RTL and testbench

//  Digital tuning controller for the VCO/mixer/DAC macro family. It drives NCH parallel DAC code buses.

---
 rtl/vco_dac_sweep_ctrl_pkg.sv | 21 ++
 rtl/vco_dac_sweep_ctrl_sd_dither1.sv | 30 +++
 rtl/vco_dac_sweep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vco_dac_sweep_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_dac_sweep_ctrl_pkg.sv
// Shared constants for the VCO/DAC sweep controller:
// FSM state codes, ramp modes and register addresses.
package vco_dac_sweep_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_REV  = 2'd2;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam logic [3:0] REG_START  = 4'd0;
    localparam logic [3:0] REG_STOP   = 4'd1;
    localparam logic [3:0] REG_STEP   = 4'd2;
    localparam logic [3:0] REG_DIV    = 4'd3;
    localparam logic [3:0] REG_MODE   = 4'd4;
    localparam logic [3:0] REG_STATIC = 4'd8;

endpackage

// File: rtl/vco_dac_sweep_ctrl_sd_dither1.sv
// First-order error-feedback modulator: the carry out of the
// running fraction sum adds one LSB on average frac/2^FRAC_W.
module sd_dither1 #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] sd_acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, sd_acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_acc <= '0;
        end else if (clr) begin
            sd_acc <= '0;
        end else if (en) begin
            sd_acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/vco_dac_sweep_ctrl.sv
// Tuning controller: config regfile, ramp FSM with prescaler and
// fractional accumulator, and registered DAC code outputs.
module vco_dac_sweep_ctrl
    import vco_dac_sweep_ctrl_pkg::*;
#(
    parameter int DAC_W    = 8,
    parameter int FRAC_W   = 4,
    parameter int NCH      = 2,
    parameter int SWEEP_CH = 0,
    parameter int DIV_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [15:0]          cfg_wdata,
    input  logic                 go,
    input  logic                 abort,
    output logic [NCH*DAC_W-1:0] dac_code,
    output logic                 busy,
    output logic                 done,
    output logic                 step_tick,
    output logic                 cfg_err
);

    localparam int ACC_W = DAC_W + FRAC_W;

    logic [DAC_W-1:0] start_code;
    logic [DAC_W-1:0] stop_code;
    logic [ACC_W-1:0] step;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic             dither;
    logic [DAC_W-1:0] static_code [NCH];

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [DIV_W-1:0] pre;
    logic             wrap;
    logic             swept;

    logic             busy_i;
    logic             start_sweep;
    logic [ACC_W-1:0] step_eff;
    logic [DAC_W-1:0] tgt;
    logic [ACC_W-1:0] tgt_acc;
    logic             up;
    logic [ACC_W:0]   sum_up;
    logic             hit;
    logic [ACC_W-1:0] next_acc;
    logic             carry;
    logic [DAC_W-1:0] int_code;
    logic [DAC_W:0]   dith_sum;
    logic [DAC_W-1:0] sweep_code;

    assign busy_i      = (state != ST_IDLE);
    assign busy        = busy_i;
    assign start_sweep = ena && go && !abort && !busy_i && (mode != MODE_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_code <= '0;
            stop_code  <= '1;
            step       <= ACC_W'(1 << FRAC_W);
            div        <= '0;
            mode       <= MODE_SINGLE;
            dither     <= 1'b0;
            for (int c = 0; c < NCH; c++) static_code[c] <= '0;
        end else if (cfg_we) begin
            if (!busy_i) begin
                case (cfg_addr)
                    REG_START: start_code <= cfg_wdata[DAC_W-1:0];
                    REG_STOP:  stop_code  <= cfg_wdata[DAC_W-1:0];
                    REG_STEP:  step       <= cfg_wdata[ACC_W-1:0];
                    REG_DIV:   div        <= cfg_wdata[DIV_W-1:0];
                    REG_MODE: begin
                        mode   <= cfg_wdata[1:0];
                        dither <= cfg_wdata[2];
                    end
                    default: ;
                endcase
            end
            for (int c = 0; c < NCH; c++) begin
                if (cfg_addr == REG_STATIC + 4'(c)) static_code[c] <= cfg_wdata[DAC_W-1:0];
            end
        end
    end

    // Direction flips between FWD and REV; a descending ramp is one with STOP < START.
    assign step_eff = (step == '0) ? ACC_W'(1) : step;
    assign tgt      = (state == ST_REV) ? start_code : stop_code;
    assign tgt_acc  = {tgt, {FRAC_W{1'b0}}};
    assign up       = (state == ST_FWD) == (stop_code >= start_code);
    assign sum_up   = {1'b0, acc} + {1'b0, step_eff};

    always_comb begin
        hit      = 1'b0;
        next_acc = acc;
        if (up) begin
            hit      = (sum_up >= {1'b0, tgt_acc});
            next_acc = hit ? tgt_acc : sum_up[ACC_W-1:0];
        end else begin
            hit      = (acc < step_eff) || ((acc - step_eff) <= tgt_acc);
            next_acc = hit ? tgt_acc : (acc - step_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            pre       <= '0;
            wrap      <= 1'b0;
            swept     <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= cfg_we && (cfg_addr <= REG_MODE) && busy_i;
            if (ena) begin
                if (abort) begin
                    state <= ST_IDLE;
                end else if (start_sweep) begin
                    state <= ST_FWD;
                    acc   <= {start_code, {FRAC_W{1'b0}}};
                    pre   <= '0;
                    wrap  <= 1'b0;
                    swept <= 1'b1;
                end else if (busy_i) begin
                    if (pre == div) begin
                        pre       <= '0;
                        step_tick <= 1'b1;
                        if (wrap) begin
                            acc  <= {start_code, {FRAC_W{1'b0}}};
                            wrap <= 1'b0;
                        end else begin
                            acc <= next_acc;
                            if (hit) begin
                                unique case (mode)
                                    MODE_SINGLE: begin
                                        state <= ST_IDLE;
                                        done  <= 1'b1;
                                    end
                                    MODE_SAW: wrap <= 1'b1;
                                    MODE_TRI: state <= (state == ST_FWD) ? ST_REV : ST_FWD;
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        pre <= pre + DIV_W'(1);
                    end
                end
            end
        end
    end

    sd_dither1 #(.FRAC_W(FRAC_W)) u_dither (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_sweep),
        .en    (ena && busy_i),
        .frac  (acc[FRAC_W-1:0]),
        .carry (carry)
    );

    assign int_code = acc[ACC_W-1:FRAC_W];
    assign dith_sum = {1'b0, int_code} + (DAC_W+1)'(carry);

    always_comb begin
        sweep_code = int_code;
        if (mode == MODE_HOLD || !swept) begin
            sweep_code = static_code[SWEEP_CH];
        end else if (busy_i && dither) begin
            sweep_code = dith_sum[DAC_W] ? '1 : dith_sum[DAC_W-1:0];
        end
    end

    // The swept channel freezes with the engine; static channels always track their register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (c == SWEEP_CH) begin
                    if (ena) dac_code[c*DAC_W +: DAC_W] <= sweep_code;
                end else begin
                    dac_code[c*DAC_W +: DAC_W] <= static_code[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_vco_dac_sweep_ctrl.sv
// Self-checking bench: directed and randomized sweeps compared
// against a ramp-list reference model built from the mode rules.
module tb_vco_dac_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        go;
    logic        abort;
    logic [15:0] dac_code;
    logic        busy;
    logic        done;
    logic        step_tick;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;
    int fwdq[$];
    int revq[$];

    vco_dac_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .go        (go),
        .abort     (abort),
        .dac_code  (dac_code),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = 16'(d);
        cyc();
        cfg_we    = 1'b0;
    endtask

    // Code list of one ramp a -> b in scaled units, terminal clamp included.
    task automatic build(input int a, input int b, input int st, input bit rev);
        int p;
        int q[$];
        p = a * 16;
        q.push_back(a);
        forever begin
            if (b >= a) begin
                p = p + st;
                if (p >= b * 16) begin q.push_back(b); break; end
            end else begin
                p = p - st;
                if (p <= b * 16) begin q.push_back(b); break; end
            end
            q.push_back(p / 16);
        end
        if (rev) revq = q;
        else fwdq = q;
    endtask

    function automatic int exp_code(input int mode, input int k);
        int n;
        int m;
        int idx;
        n = fwdq.size() - 1;
        m = revq.size() - 1;
        if (mode == 0) return (k >= n) ? fwdq[n] : fwdq[k];
        if (mode == 1) return fwdq[k % (n + 1)];
        idx = k % (n + m);
        return (idx < n) ? fwdq[idx] : revq[idx - n];
    endfunction

    task automatic run_sweep(input int mode, input int start, input int stop, input int step,
                             input int div, input int ncyc, input int frz_at, input int frz_len);
        int st;
        int n;
        int end_c;
        int c;
        int k;
        logic [7:0] last;
        wr(4'd0, start);
        wr(4'd1, stop);
        wr(4'd2, step);
        wr(4'd3, div);
        wr(4'd4, mode);
        st = (step == 0) ? 1 : step;
        build(start, stop, st, 1'b0);
        build(stop, start, st, 1'b1);
        n = fwdq.size() - 1;
        end_c = (div + 1) * n;
        go = 1'b1;
        cyc();
        go = 1'b0;
        c = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (c == frz_at && frz_len > 0) begin
                ena = 1'b0;
                last = dac_code[7:0];
                for (int j = 0; j < frz_len; j++) begin
                    cyc();
                    check("freeze_code", dac_code[7:0], last);
                    check("freeze_tick", step_tick, 0);
                end
                ena = 1'b1;
            end
            cyc();
            c++;
            k = (c - 1) / (div + 1);
            check("sweep_code", dac_code[7:0], exp_code(mode, k));
            check("step_tick", step_tick, (c % (div + 1) == 0) && (mode != 0 || c <= end_c));
            if (mode == 0) begin
                check("single_busy", busy, c < end_c);
                check("single_done", done, c == end_c);
            end
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_idle", busy, 0);
    endtask

    initial begin
        logic [7:0] prev;
        rst_n = 1'b0;
        ena = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        go = 1'b0;
        abort = 1'b0;
        #12;
        check("rst_code", dac_code, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, step_tick, cfg_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        wr(4'd9, 'hA5);
        check("static_lat0", dac_code[15:8], 0);
        cyc();
        check("static_ch1", dac_code[15:8], 'hA5);
        check("static_ch0", dac_code[7:0], 0);

        run_sweep(0, 10, 14, 16, 2, 16, -1, 0);
        run_sweep(2, 20, 5, 96, 0, 12, -1, 0);
        run_sweep(1, 30, 40, 16, 3, 60, 17, 7);
        run_sweep(1, 77, 77, 16, 1, 8, -1, 0);
        run_sweep(0, 60, 60, 16, 2, 6, -1, 0);
        for (int r = 0; r < 6; r++) begin
            run_sweep($urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 300), $urandom_range(0, 3), 40, -1, 0);
        end

        go = 1'b1;
        abort = 1'b1;
        cyc();
        go = 1'b0;
        abort = 1'b0;
        check("go_abort_busy", busy, 0);
        cyc();
        check("go_abort_busy2", busy, 0);

        wr(4'd0, 0);
        wr(4'd1, 2);
        wr(4'd2, 16);
        wr(4'd3, 0);
        wr(4'd4, 1);
        go = 1'b1;
        cyc();
        go = 1'b0;
        wr(4'd4, 0);
        check("cfg_err_pulse", cfg_err, 1);
        cyc();
        check("cfg_err_clear", cfg_err, 0);
        repeat (8) cyc();
        check("mode_kept_saw", busy, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        wr(4'd0, 50);
        wr(4'd1, 60);
        wr(4'd3, 4);
        wr(4'd4, 0);
        go = 1'b1;
        cyc();
        go = 1'b0;
        repeat (12) cyc();
        go = 1'b1;
        cyc();
        go = 1'b0;
        cyc();
        check("go_busy_ignored", dac_code[7:0], 52);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        wr(4'd0, 100);
        wr(4'd1, 110);
        wr(4'd2, 8);
        wr(4'd3, 20);
        wr(4'd4, 4);
        go = 1'b1;
        cyc();
        go = 1'b0;
        repeat (5) cyc();
        check("dither_int", dac_code[7:0], 100);
        repeat (19) cyc();
        prev = dac_code[7:0];
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("dither_alt", 32'(prev) + 32'(dac_code[7:0]), 201);
            check("dither_low", dac_code[7:0] >= 8'd100, 1);
            prev = dac_code[7:0];
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        check("idle_keeps_int", dac_code[7:0], 100);

        wr(4'd0, 255);
        wr(4'd1, 255);
        wr(4'd3, 0);
        wr(4'd4, 5);
        go = 1'b1;
        cyc();
        go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("dither_sat", dac_code[7:0], 255);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        wr(4'd4, 3);
        wr(4'd8, 'h3C);
        cyc();
        check("hold_static", dac_code[7:0], 'h3C);
        go = 1'b1;
        cyc();
        go = 1'b0;
        check("hold_go_ignored", busy, 0);
        cyc();
        check("hold_static2", dac_code[7:0], 'h3C);

        wr(4'd4, 1);
        wr(4'd0, 0);
        wr(4'd1, 200);
        go = 1'b1;
        cyc();
        go = 1'b0;
        repeat (5) cyc();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_code", dac_code, 0);
        check("arst_busy", busy, 0);
        check("arst_flags", {done, step_tick, cfg_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("post_rst_code", dac_code, 0);
        go = 1'b1;
        cyc();
        go = 1'b0;
        cyc();
        check("default_start", dac_code[7:0], 0);
        cyc();
        check("default_step1", dac_code[7:0], 1);
        cyc();
        check("default_step2", dac_code[7:0], 2);
        check("default_busy", busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
